// File: rtl/dram_responder_pkg.sv
// Shared request types, access-size encoding and byte-lane helpers for the
// data-memory responder.
package dram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2
    } msize_t;

    typedef struct packed {
        logic        ren;
        logic [31:0] addr;
        logic [1:0]  size;
    } m_r_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
    } m_w_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dram_state_t;

    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'(MSIZE_B): be_of = 4'b0001 << a;
            2'(MSIZE_H): be_of = 4'b0011 << a;
            default:     be_of = 4'b1111;
        endcase
    endfunction

    // Size 3 behaves as a word access, so it carries the word alignment rule.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'(MSIZE_B): misaligned = 1'b0;
            2'(MSIZE_H): misaligned = a[0];
            default:     misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dram_responder_bank.sv
// Word-organised data RAM with per-byte write enables and a registered read
// port whose output register holds the last completed read.
module dram_responder_bank
    import dram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [3:0]           we,
    input  logic [31:0]          wd,
    input  logic                 re,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder: accepts one read/write at a time, completes it a fixed
// LATENCY cycles later, and stalls the pipeline while the request is in flight.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  m_r_t        mread,
    input  m_w_t        mwrite,
    output logic [31:0] rd,
    output logic        data_ok,
    output logic        stall,
    output logic        addr_err
);

    localparam bit         DIRECT   = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dram_state_t            state_q;
    logic [3:0]             cnt_q;
    logic                   op_wr_q;
    logic [ADDR_BITS+1:0]   addr_q;
    logic [31:0]            wd_q;
    logic [1:0]             size_q;
    logic                   data_ok_q;
    logic                   addr_err_q;

    logic                   req;
    logic                   accept;
    logic                   in_wr;
    logic [ADDR_BITS+1:0]   in_addr;
    logic [1:0]             in_size;
    logic                   src_wr;
    logic [ADDR_BITS+1:0]   src_addr;
    logic [31:0]            src_wd;
    logic [1:0]             src_size;
    logic                   access;
    logic                   mis;
    logic [3:0]             bank_we;
    logic                   bank_re;
    logic                   unused_addr_hi;

    // Write wins when both strobes are up; the read is silently dropped.
    assign req     = mread.ren | mwrite.wen;
    assign accept  = (state_q != ST_WAIT) && req;
    assign in_wr   = mwrite.wen;
    assign in_addr = in_wr ? mwrite.addr[ADDR_BITS+1:0] : mread.addr[ADDR_BITS+1:0];
    assign in_size = in_wr ? mwrite.size : mread.size;

    // With a one-cycle latency the RAM is accessed on the accepting edge, so it
    // must see the live request rather than the latch.
    assign src_wr   = DIRECT ? in_wr      : op_wr_q;
    assign src_addr = DIRECT ? in_addr    : addr_q;
    assign src_wd   = DIRECT ? mwrite.wd  : wd_q;
    assign src_size = DIRECT ? in_size    : size_q;

    assign access  = !reset && (DIRECT ? accept : (state_q == ST_WAIT && cnt_q == 4'd1));
    assign mis     = misaligned(src_size, src_addr[1:0]);
    assign bank_we = (access && src_wr && !mis) ? be_of(src_size, src_addr[1:0]) : 4'b0000;
    assign bank_re = access && !src_wr && !mis;

    assign stall    = !reset && ((state_q == ST_WAIT) || accept);
    assign data_ok  = data_ok_q;
    assign addr_err = addr_err_q;

    assign unused_addr_hi = ^{mread.addr[31:ADDR_BITS+2], mwrite.addr[31:ADDR_BITS+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            data_ok_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            data_ok_q  <= access;
            addr_err_q <= access && mis;
            case (state_q)
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    // RESP doubles as an accept cycle, giving back-to-back service.
                    if (req) begin
                        op_wr_q <= in_wr;
                        addr_q  <= in_addr;
                        wd_q    <= mwrite.wd;
                        size_q  <= in_size;
                        cnt_q   <= CNT_INIT;
                        state_q <= DIRECT ? ST_RESP : ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    dram_responder_bank #(
        .ADDR_BITS(ADDR_BITS)
    ) u_bank (
        .clk  (clk),
        .rst  (reset),
        .idx  (src_addr[ADDR_BITS+1:2]),
        .we   (bank_we),
        .wd   (src_wd),
        .re   (bank_re),
        .rdata(rd)
    );

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: a cycle-level reference model checked every cycle,
// plus directed literal checks and a randomized phase.
module tb_dram_responder;
    import dram_responder_pkg::*;

    localparam int AB    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 2 ** AB;

    logic        clk = 1'b0;
    logic        reset;
    m_r_t        mread;
    m_w_t        mwrite;
    logic [31:0] rd;
    logic        data_ok;
    logic        stall;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    dram_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .mread   (mread),
        .mwrite  (mwrite),
        .rd      (rd),
        .data_ok (data_ok),
        .stall   (stall),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: what the outputs must be in each cycle.
    logic [31:0] mem_m [DEPTH];
    bit          model_en = 0;
    bit          pend_v = 0;
    int          pend_done;
    bit          pend_wr;
    logic [31:0] pend_addr;
    logic [31:0] pend_wd;
    int          pend_sz;
    logic [31:0] e_rd = 32'h0;
    bit          e_dok, e_err, e_stall, done, req_now, mis_m;
    int          idx_m, base_m;

    function automatic int eff_size(input logic [1:0] s);
        return (s == 2'd3) ? 2 : int'(s);
    endfunction

    always @(negedge clk) begin
        if (model_en) begin
            done  = pend_v && (pend_done == cyc);
            e_dok = done;
            e_err = 1'b0;
            if (done) begin
                base_m = int'(pend_addr % 4);
                idx_m  = int'((pend_addr / 4) % DEPTH);
                mis_m  = (pend_sz == 1 && (pend_addr % 2) != 0) ||
                         (pend_sz == 2 && base_m != 0);
                if (mis_m) begin
                    e_err = 1'b1;
                end else if (pend_wr) begin
                    for (int k = 0; k < (1 << pend_sz); k++)
                        mem_m[idx_m][8*(base_m+k) +: 8] = pend_wd[8*(base_m+k) +: 8];
                end else begin
                    e_rd = mem_m[idx_m];
                end
            end
            req_now = mread.ren || mwrite.wen;
            e_stall = !reset && ((pend_v && !done) || req_now);

            checks += 4;
            if (rd !== e_rd) begin
                errors++; $display("FAIL cyc%0d rd act=%h exp=%h", cyc, rd, e_rd);
            end
            if (data_ok !== e_dok) begin
                errors++; $display("FAIL cyc%0d data_ok act=%b exp=%b", cyc, data_ok, e_dok);
            end
            if (stall !== e_stall) begin
                errors++; $display("FAIL cyc%0d stall act=%b exp=%b", cyc, stall, e_stall);
            end
            if (addr_err !== e_err) begin
                errors++; $display("FAIL cyc%0d addr_err act=%b exp=%b", cyc, addr_err, e_err);
            end

            if (reset) begin
                pend_v = 0;
                e_rd   = 32'h0;
            end else begin
                if (done) pend_v = 0;
                if (req_now && !pend_v) begin
                    pend_v    = 1;
                    pend_done = cyc + LAT;
                    pend_wr   = mwrite.wen;
                    pend_addr = mwrite.wen ? mwrite.addr : mread.addr;
                    pend_sz   = eff_size(mwrite.wen ? mwrite.size : mread.size);
                    pend_wd   = mwrite.wd;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mread  = '0;
        mwrite = '0;
    endtask

    task automatic do_req(input bit r, input bit w, input logic [31:0] ra, input logic [31:0] wa,
                          input logic [31:0] d, input logic [1:0] s,
                          output logic [31:0] rdv, output logic err, output int lat);
        @(posedge clk); #1;
        mread.ren  = r;  mread.addr  = ra; mread.size  = s;
        mwrite.wen = w;  mwrite.addr = wa; mwrite.wd   = d; mwrite.size = s;
        @(posedge clk); #1;
        idle_inputs();
        lat = 1;
        while (data_ok !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdv = rd;
        err = addr_err;
    endtask

    logic [31:0] v;
    logic        e;
    int          l;

    task automatic wr(input string n, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic exp_err);
        do_req(1'b0, 1'b1, 32'h0, a, d, s, v, e, l);
        chk({n, "_lat"}, 32'(l), 32'(LAT));
        chk({n, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic rdq(input string n, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] exp_rd, input logic exp_err);
        do_req(1'b1, 1'b0, a, 32'h0, 32'h0, s, v, e, l);
        chk({n, "_lat"}, 32'(l), 32'(LAT));
        chk({n, "_rd"}, v, exp_rd);
        chk({n, "_err"}, 32'(e), 32'(exp_err));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        model_en = 1;
        chk("rst_rd", rd, 32'h0);
        chk("rst_dok", 32'(data_ok), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Give every RAM word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b0, 1'b1, 32'h0, 32'(i * 4), $urandom, 2'd2, v, e, l);
            if (l != LAT) chk("init_lat", 32'(l), 32'(LAT));
        end

        // Stall asserted in the presentation cycle.
        @(posedge clk); #1;
        mwrite = '{wen: 1'b1, addr: 32'h40, wd: 32'h1234_5678, size: 2'd2};
        #2 chk("stall_same_cycle", 32'(stall), 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        chk("stall_wait", 32'(stall), 32'h1);
        @(posedge clk); #1;
        chk("t1_wr_dok", 32'(data_ok), 32'h1);
        chk("stall_resp", 32'(stall), 32'h0);
        rdq("t1_rd", 32'h40, 2'd2, 32'h1234_5678, 1'b0);

        wr("t2_word", 32'h80, 32'hAABB_CCDD, 2'd2, 1'b0);
        wr("t2_byte", 32'h81, 32'h0000_EE00, 2'd0, 1'b0);
        rdq("t2_rd", 32'h80, 2'd2, 32'hAABB_EEDD, 1'b0);

        rdq("t3_half_ok", 32'h42, 2'd1, 32'h1234_5678, 1'b0);
        rdq("t3_half_bad", 32'h43, 2'd1, 32'h1234_5678, 1'b1);
        wr("t3_word_bad", 32'h43, 32'hDEAD_BEEF, 2'd2, 1'b1);
        rdq("t3_old", 32'h40, 2'd3, 32'h1234_5678, 1'b0);

        wr("t4_wrap", 32'h0000_1000, 32'h1, 2'd2, 1'b0);
        rdq("t4_rd0", 32'h0, 2'd2, 32'h1, 1'b0);
        do_req(1'b1, 1'b1, 32'h24, 32'h20, 32'h55, 2'd2, v, e, l);
        chk("t4_both_rd", v, 32'h1);
        chk("t4_both_err", 32'(e), 32'h0);
        rdq("t4_after", 32'h20, 2'd2, 32'h55, 1'b0);

        // Back-to-back: second read presented in the data_ok cycle.
        @(posedge clk); #1;
        mread = '{ren: 1'b1, addr: 32'h80, size: 2'd2};
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        chk("t5_dok1", 32'(data_ok), 32'h1);
        chk("t5_rd1", rd, 32'hAABB_EEDD);
        mread = '{ren: 1'b1, addr: 32'h40, size: 2'd2};
        @(posedge clk); #1;
        idle_inputs();
        chk("t5_gap", 32'(data_ok), 32'h0);
        @(posedge clk); #1;
        chk("t5_dok2", 32'(data_ok), 32'h1);
        chk("t5_rd2", rd, 32'h1234_5678);

        // Reset while a write sits in WAIT.
        wr("t6_prior", 32'h10, 32'h0BAD_F00D, 2'd2, 1'b0);
        @(posedge clk); #1;
        mwrite = '{wen: 1'b1, addr: 32'h10, wd: 32'hFFFF_FFFF, size: 2'd2};
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_dok", 32'(data_ok), 32'h0);
            chk("t6_no_stall", 32'(stall), 32'h0);
            @(posedge clk); #1;
        end
        chk("t6_rd_rst", rd, 32'h0);
        rdq("t6_rd", 32'h10, 2'd2, 32'h0BAD_F00D, 1'b0);

        // Randomized traffic, including requests held while busy and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            mread.ren   = ($urandom_range(0, 2) == 0);
            mread.addr  = ($urandom_range(0, 3) << 12) | $urandom_range(0, 255);
            mread.size  = 2'($urandom_range(0, 3));
            mwrite.wen  = ($urandom_range(0, 2) == 0);
            mwrite.addr = ($urandom_range(0, 3) << 12) | $urandom_range(0, 255);
            mwrite.wd   = $urandom;
            mwrite.size = 2'($urandom_range(0, 3));
            reset       = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
